// File: rtl/dcache_resp_pkg.sv
// Shared types and geometry for the data cache: FSM states, address
// split, frame layout and a block-address helper.
package dcache_resp_pkg;

    localparam int DTAG_W = 26;
    localparam int DSETS  = 8;
    localparam int DWAYS  = 2;
    localparam int DIDX_W = 3;

    typedef enum logic [2:0] {
        IDLE,
        WB0,
        WB1,
        LD0,
        LD1,
        FLUSH,
        DONE
    } dcache_state_t;

    typedef struct packed {
        logic [DTAG_W-1:0] tag;
        logic [DIDX_W-1:0] idx;
        logic              blkoff;
        logic [1:0]        bytoff;
    } dcachef_t;

    typedef struct packed {
        logic              valid;
        logic              dirty;
        logic [DTAG_W-1:0] tag;
        logic [1:0][31:0]  data;
    } dcache_frame_t;

    function automatic logic [31:0] blk_addr(
        input logic [DTAG_W-1:0] tag,
        input logic [DIDX_W-1:0] idx,
        input logic              off
    );
        return {tag, idx, off, 2'b00};
    endfunction

endpackage

// File: rtl/dcache_resp_if.sv
// Datapath and memory-side signals of the data cache.
// slave: the cache; master: the datapath/memory environment.
interface dcache_resp_if;
    import dcache_resp_pkg::*;

    logic        halt;
    logic        dmemREN;
    logic        dmemWEN;
    logic        datomic;
    logic [31:0] dmemaddr;
    logic [31:0] dmemstore;
    logic        dhit;
    logic [31:0] dmemload;
    logic        flushed;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic [31:0] dload;
    logic        dwait;

    modport slave (
        input  halt, dmemREN, dmemWEN, datomic, dmemaddr, dmemstore,
        input  dload, dwait,
        output dhit, dmemload, flushed, dREN, dWEN, daddr, dstore
    );

    modport master (
        output halt, dmemREN, dmemWEN, datomic, dmemaddr, dmemstore,
        output dload, dwait,
        input  dhit, dmemload, flushed, dREN, dWEN, daddr, dstore
    );

endinterface

// File: rtl/dcache_resp_lru.sv
// Per-set LRU bits; each bit names the victim way of its set.
// Ports: hit_en/hit_idx/hit_way update, q_idx -> victim query.
module dcache_lru
    import dcache_resp_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              hit_en,
    input  logic [DIDX_W-1:0] hit_idx,
    input  logic              hit_way,
    input  logic [DIDX_W-1:0] q_idx,
    output logic              victim
);

    logic [DSETS-1:0] lru;

    always_ff @(posedge CLK) begin
        if (RST) begin
            lru <= '0;
        end else if (hit_en) begin
            lru[hit_idx] <= ~hit_way;
        end
    end

    assign victim = lru[q_idx];

endmodule

// File: rtl/dcache_resp.sv
// 2-way write-back data cache with LL/SC link and halt-triggered flush.
// Ports: CLK, RST (sync, active-high), dif (slave: datapath + memory bus).
module dcache_resp
    import dcache_resp_pkg::*;
(
    input  logic         CLK,
    input  logic         RST,
    dcache_resp_if.slave dif
);

    dcache_state_t state;
    dcache_frame_t frames [DWAYS][DSETS];
    dcachef_t      a;
    dcache_frame_t hfr;
    dcache_frame_t vfr;
    dcache_frame_t cfr;
    dcache_frame_t ffr;

    logic        miss_way;
    logic [4:0]  fcnt;
    logic        fword;
    logic [29:0] linkaddr;
    logic        linkvalid;

    logic req;
    logic wr;
    logic is_ll;
    logic is_sc;
    logic sc_ok;
    logic sc_fail;
    logic hit0;
    logic hit1;
    logic hit;
    logic hit_way;
    logic victim;
    logic dhit;
    logic commit;
    logic fdirty;
    logic xfer_done;
    logic wb_word;
    logic unused_bits;

    assign a = dcachef_t'(dif.dmemaddr);

    // Requests are ignored once halt is raised.
    assign req     = !dif.halt && (dif.dmemREN || dif.dmemWEN);
    assign wr      = dif.dmemWEN;
    assign is_ll   = dif.datomic && dif.dmemREN && !dif.dmemWEN;
    assign is_sc   = dif.datomic && dif.dmemWEN;
    assign sc_ok   = linkvalid && (linkaddr == dif.dmemaddr[31:2]);
    assign sc_fail = is_sc && !sc_ok;

    assign hit0    = frames[0][a.idx].valid && (frames[0][a.idx].tag == a.tag);
    assign hit1    = frames[1][a.idx].valid && (frames[1][a.idx].tag == a.tag);
    assign hit     = hit0 || hit1;
    assign hit_way = hit1;

    assign hfr = frames[hit_way][a.idx];
    assign vfr = frames[miss_way][a.idx];
    assign cfr = frames[victim][a.idx];
    assign ffr = frames[fcnt[3]][fcnt[2:0]];

    assign fdirty    = ffr.valid && ffr.dirty;
    assign xfer_done = !dif.dwait;
    assign wb_word   = (state == WB1);

    // A failing SC completes immediately without touching cache or memory.
    assign dhit   = (state == IDLE) && req && (hit || sc_fail);
    assign commit = dhit && !sc_fail;

    assign unused_bits = ^{a.bytoff, fcnt[4]};

    dcache_lru u_lru (
        .CLK     (CLK),
        .RST     (RST),
        .hit_en  (commit),
        .hit_idx (a.idx),
        .hit_way (hit_way),
        .q_idx   (a.idx),
        .victim  (victim)
    );

    assign dif.dhit    = dhit;
    assign dif.flushed = (state == DONE);

    always_comb begin
        dif.dmemload = '0;
        if (dhit) begin
            if (is_sc) begin
                dif.dmemload = {31'd0, sc_ok};
            end else begin
                dif.dmemload = hfr.data[a.blkoff];
            end
        end
    end

    always_comb begin
        dif.dREN   = 1'b0;
        dif.dWEN   = 1'b0;
        dif.daddr  = '0;
        dif.dstore = '0;
        unique case (state)
            WB0, WB1: begin
                dif.dWEN   = 1'b1;
                dif.daddr  = blk_addr(vfr.tag, a.idx, wb_word);
                dif.dstore = vfr.data[wb_word];
            end
            LD0, LD1: begin
                dif.dREN  = 1'b1;
                dif.daddr = blk_addr(a.tag, a.idx, state == LD1);
            end
            FLUSH: begin
                if (fdirty) begin
                    dif.dWEN   = 1'b1;
                    dif.daddr  = blk_addr(ffr.tag, fcnt[2:0], fword);
                    dif.dstore = ffr.data[fword];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            miss_way  <= 1'b0;
            fcnt      <= '0;
            fword     <= 1'b0;
            linkaddr  <= '0;
            linkvalid <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (dif.halt) begin
                        state <= FLUSH;
                    end else if (req && !hit && !sc_fail) begin
                        miss_way <= victim;
                        state    <= (cfr.valid && cfr.dirty) ? WB0 : LD0;
                    end
                    if (dhit) begin
                        if (is_ll) begin
                            linkaddr  <= dif.dmemaddr[31:2];
                            linkvalid <= 1'b1;
                        end else if (is_sc) begin
                            linkvalid <= 1'b0;
                        end else if (wr && dif.dmemaddr[31:2] == linkaddr) begin
                            linkvalid <= 1'b0;
                        end
                    end
                end
                WB0: if (xfer_done) state <= WB1;
                WB1: if (xfer_done) state <= LD0;
                LD0: if (xfer_done) state <= LD1;
                LD1: if (xfer_done) state <= dif.halt ? FLUSH : IDLE;
                FLUSH: begin
                    if (!fdirty || xfer_done) begin
                        if (fdirty && !fword) begin
                            fword <= 1'b1;
                        end else begin
                            fword <= 1'b0;
                            if (fcnt == 5'd15) begin
                                state <= DONE;
                            end else begin
                                fcnt <= fcnt + 5'd1;
                            end
                        end
                    end
                end
                DONE: ;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int w = 0; w < DWAYS; w++) begin
                for (int s = 0; s < DSETS; s++) begin
                    frames[w][s].valid <= 1'b0;
                    frames[w][s].dirty <= 1'b0;
                end
            end
        end else begin
            if (commit && wr) begin
                frames[hit_way][a.idx].data[a.blkoff] <= dif.dmemstore;
                frames[hit_way][a.idx].dirty          <= 1'b1;
            end
            // Frame is unusable while half refilled.
            if (state == LD0 && xfer_done) begin
                frames[miss_way][a.idx].data[0] <= dif.dload;
                frames[miss_way][a.idx].valid   <= 1'b0;
            end
            if (state == LD1 && xfer_done) begin
                frames[miss_way][a.idx].data[1] <= dif.dload;
                frames[miss_way][a.idx].valid   <= 1'b1;
                frames[miss_way][a.idx].dirty   <= 1'b0;
                frames[miss_way][a.idx].tag     <= a.tag;
            end
        end
    end

endmodule

// File: tb/tb_dcache_resp.sv
// Directed scoreboard bench for dcache_resp with a one-wait-state
// memory model that logs every completed transfer.
module tb_dcache_resp;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    dcache_resp_if dif();

    dcache_resp dut (
        .CLK (CLK),
        .RST (RST),
        .dif (dif.slave)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit          we;
        logic [31:0] a;
        logic [31:0] d;
    } xfer_t;

    xfer_t       xlog[$];
    logic [31:0] exp_q[$];
    logic [31:0] mem [logic [31:0]];
    int          vectors = 0;
    int          miscompares = 0;
    int          wcnt = 0;
    int          last_cyc = 0;

    function automatic logic [31:0] rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ 32'hDEAD0000;
    endfunction

    // Each transfer sees one dwait=1 cycle, then completes.
    always @(negedge CLK) begin
        dif.dload = rd(dif.daddr);
        if (RST || !(dif.dREN || dif.dWEN)) begin
            dif.dwait = 1'b1;
            wcnt = 0;
        end else if (wcnt < 1) begin
            wcnt++;
            dif.dwait = 1'b1;
        end else begin
            dif.dwait = 1'b0;
            wcnt = 0;
            xlog.push_back('{dif.dWEN, dif.daddr,
                             dif.dWEN ? dif.dstore : dif.dload});
            if (dif.dWEN) mem[dif.daddr] = dif.dstore;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_x(input string tag, input int i, input bit we,
                         input logic [31:0] a, input logic [31:0] d);
        if (i < xlog.size()) begin
            chk({tag, "_we"}, {31'd0, xlog[i].we}, {31'd0, we});
            chk({tag, "_addr"}, xlog[i].a, a);
            if (we) chk({tag, "_data"}, xlog[i].d, d);
        end else begin
            chk({tag, "_missing"}, xlog.size(), i + 1);
        end
    endtask

    task automatic access(input string tag, input bit ren, input bit wen,
                          input bit at, input logic [31:0] a,
                          input logic [31:0] d, input bit has_exp,
                          input logic [31:0] exp);
        int cyc;
        @(negedge CLK);
        dif.dmemREN   = ren;
        dif.dmemWEN   = wen;
        dif.datomic   = at;
        dif.dmemaddr  = a;
        dif.dmemstore = d;
        if (has_exp) exp_q.push_back(exp);
        cyc = 0;
        #1;
        while (dif.dhit !== 1'b1 && cyc < 100) begin
            @(negedge CLK);
            #1;
            cyc++;
        end
        if (dif.dhit !== 1'b1) begin
            chk({tag, "_dhit"}, {31'd0, dif.dhit}, 32'd1);
            if (has_exp) void'(exp_q.pop_back());
        end else if (has_exp) begin
            chk(tag, dif.dmemload, exp_q.pop_front());
        end
        last_cyc = cyc;
        @(posedge CLK);
        #1;
        dif.dmemREN = 1'b0;
        dif.dmemWEN = 1'b0;
        dif.datomic = 1'b0;
    endtask

    task automatic lw(input string t, input logic [31:0] a,
                      input logic [31:0] e);
        access(t, 1'b1, 1'b0, 1'b0, a, 32'd0, 1'b1, e);
    endtask

    task automatic sw(input string t, input logic [31:0] a,
                      input logic [31:0] d);
        access(t, 1'b0, 1'b1, 1'b0, a, d, 1'b0, 32'd0);
    endtask

    task automatic ll(input string t, input logic [31:0] a,
                      input logic [31:0] e);
        access(t, 1'b1, 1'b0, 1'b1, a, 32'd0, 1'b1, e);
    endtask

    task automatic sc(input string t, input logic [31:0] a,
                      input logic [31:0] d, input logic [31:0] e);
        access(t, 1'b0, 1'b1, 1'b1, a, d, 1'b1, e);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1;
        dif.halt = 1'b0;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
    endtask

    initial begin
        logic [31:0] e44;
        logic [31:0] e8c;
        logic [31:0] e40;
        int          n;

        dif.halt      = 1'b0;
        dif.dmemREN   = 1'b0;
        dif.dmemWEN   = 1'b0;
        dif.datomic   = 1'b0;
        dif.dmemaddr  = '0;
        dif.dmemstore = '0;
        dif.dwait     = 1'b1;
        dif.dload     = '0;
        mem[32'h40]  = 32'hAAAA5555;
        mem[32'h100] = 32'h5A5A5A5A;

        RST = 1'b1;
        repeat (3) @(negedge CLK);
        #1;
        chk("rst_dhit", {31'd0, dif.dhit}, 32'd0);
        chk("rst_dREN", {31'd0, dif.dREN}, 32'd0);
        chk("rst_dWEN", {31'd0, dif.dWEN}, 32'd0);
        chk("rst_daddr", dif.daddr, 32'd0);
        chk("rst_dstore", dif.dstore, 32'd0);
        chk("rst_dmemload", dif.dmemload, 32'd0);
        chk("rst_flushed", {31'd0, dif.flushed}, 32'd0);
        @(negedge CLK);
        RST = 1'b0;

        // cold miss: two refill reads, hit in first IDLE cycle
        xlog.delete();
        lw("lw40_miss", 32'h40, 32'hAAAA5555);
        chk("lw40_lat", last_cyc, 32'd5);
        chk("lw40_nx", xlog.size(), 32'd2);
        chk_x("lw40_x0", 0, 1'b0, 32'h40, 32'd0);
        chk_x("lw40_x1", 1, 1'b0, 32'h44, 32'd0);

        // store and load hits: same-cycle, no traffic
        xlog.delete();
        sw("sw40", 32'h40, 32'h1234);
        chk("sw40_lat", last_cyc, 32'd0);
        lw("lw40_hit", 32'h40, 32'h1234);
        chk("lw40_hit_lat", last_cyc, 32'd0);
        chk("hit_nx", xlog.size(), 32'd0);

        // fill other way, then evict the dirty 0x40 block
        e44 = rd(32'h44);
        lw("lw80", 32'h80, rd(32'h80));
        chk("lw80_lat", last_cyc, 32'd5);
        xlog.delete();
        lw("lwC0", 32'hC0, rd(32'hC0));
        chk("lwC0_lat", last_cyc, 32'd9);
        chk("lwC0_nx", xlog.size(), 32'd4);
        chk_x("evict_x0", 0, 1'b1, 32'h40, 32'h1234);
        chk_x("evict_x1", 1, 1'b1, 32'h44, e44);
        chk_x("evict_x2", 2, 1'b0, 32'hC0, 32'd0);
        chk_x("evict_x3", 3, 1'b0, 32'hC4, 32'd0);

        // LL/SC success, then repeat SC fails
        ll("ll100", 32'h100, 32'h5A5A5A5A);
        sc("sc100_ok", 32'h100, 32'd7, 32'd1);
        chk("sc100_ok_lat", last_cyc, 32'd0);
        lw("lw100_a", 32'h100, 32'd7);
        sc("sc100_again", 32'h100, 32'd9, 32'd0);
        lw("lw100_b", 32'h100, 32'd7);

        // failing SC to an uncached address: immediate, no traffic
        xlog.delete();
        sc("sc200_nolink", 32'h200, 32'd3, 32'd0);
        chk("sc200_lat", last_cyc, 32'd0);
        chk("sc200_nx", xlog.size(), 32'd0);

        // intervening store to the link breaks it
        ll("ll100_b", 32'h100, 32'd7);
        sw("sw100", 32'h100, 32'h55);
        sc("sc100_broken", 32'h100, 32'h66, 32'd0);
        lw("lw100_c", 32'h100, 32'h55);

        // store to the neighbour word leaves the link intact
        ll("ll100_c", 32'h100, 32'h55);
        sw("sw104", 32'h104, 32'h77);
        sc("sc100_kept", 32'h100, 32'h88, 32'd1);
        lw("lw100_d", 32'h100, 32'h88);
        lw("lw104", 32'h104, 32'h77);

        // flush of two dirty frames
        do_reset();
        sw("sw40_f", 32'h40, 32'hCAFE0040);
        sw("sw88_f", 32'h88, 32'hBEEF0088);
        e44 = rd(32'h44);
        e8c = rd(32'h8C);
        xlog.delete();
        @(negedge CLK);
        dif.halt = 1'b1;
        n = 0;
        #1;
        while (dif.flushed !== 1'b1 && n < 200) begin
            @(negedge CLK);
            #1;
            n++;
        end
        chk("flush_done", {31'd0, dif.flushed}, 32'd1);
        chk("flush_nx", xlog.size(), 32'd4);
        chk_x("flush_x0", 0, 1'b1, 32'h40, 32'hCAFE0040);
        chk_x("flush_x1", 1, 1'b1, 32'h44, e44);
        chk_x("flush_x2", 2, 1'b1, 32'h88, 32'hBEEF0088);
        chk_x("flush_x3", 3, 1'b1, 32'h8C, e8c);
        dif.halt = 1'b0;
        repeat (3) @(negedge CLK);
        #1;
        chk("done_hold", {31'd0, dif.flushed}, 32'd1);
        chk("done_quiet", {30'd0, dif.dREN, dif.dWEN}, 32'd0);
        chk("done_nx", xlog.size(), 32'd4);

        // reset in the middle of a flush discards the dirty block
        do_reset();
        sw("sw40_r", 32'h40, 32'h11);
        e40 = rd(32'h40);
        xlog.delete();
        @(negedge CLK);
        dif.halt = 1'b1;
        n = 0;
        #1;
        while (dif.dWEN !== 1'b1 && n < 50) begin
            @(negedge CLK);
            #1;
            n++;
        end
        chk("midflush_dWEN", {31'd0, dif.dWEN}, 32'd1);
        RST = 1'b1;
        @(negedge CLK);
        #1;
        chk("midrst_flushed", {31'd0, dif.flushed}, 32'd0);
        chk("midrst_dWEN", {31'd0, dif.dWEN}, 32'd0);
        chk("midrst_nx", xlog.size(), 32'd0);
        RST = 1'b0;
        dif.halt = 1'b0;
        lw("lw40_after", 32'h40, e40);
        chk("lw40_after_lat", last_cyc, 32'd5);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
